serial_sub: RTL and testbench



---
 rtl/serial_sub_pkg.sv | 19 +
 rtl/serial_sub_if.sv | 36 +++
 rtl/serial_sub_full_sub.sv | 34 +++
 rtl/serial_sub.sv | 148 ++++++++++++++
 tb/tb_serial_sub.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
// Package    : serial_sub_defs
// Purpose    : Shared constants for the bit-serial subtractor: state
//              encoding and the default operand width.
// Contents   : ST_IDLE / ST_SHIFT / ST_DONE (2-bit state codes)
//              DEFAULT_WIDTH (default operand/result width)
// Revision   : 1.0  initial release
// ============================================================================
package serial_sub_defs;

   localparam int unsigned DEFAULT_WIDTH = 8;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

endpackage : serial_sub_defs
`default_nettype wire

// File: rtl/serial_sub_if.sv
`default_nettype none
// ============================================================================
// Interface  : serial_sub_if
// Purpose    : Handshake and operand/result bundle of the bit-serial
//              subtractor.
// Signals    : start        request, sampled only when busy=0
//              a, b         operands, captured on the accepting edge
//              busy         high while bits are processed
//              done         one-cycle result-valid pulse
//              diff, bout   result and final borrow
//              ovf          signed overflow (only with SERIAL_SUB_OVF_EN)
// Modports   : master (requester), slave (subtractor)
// Options    : SERIAL_SUB_OVF_EN adds the ovf signal
// Revision   : 1.0  initial release
// ============================================================================
interface serial_sub_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf;

   modport master (output start, a, b, input  busy, done, diff, bout, ovf);
   modport slave  (input  start, a, b, output busy, done, diff, bout, ovf);
`else
   modport master (output start, a, b, input  busy, done, diff, bout);
   modport slave  (input  start, a, b, output busy, done, diff, bout);
`endif
endinterface : serial_sub_if
`default_nettype wire

// File: rtl/serial_sub_full_sub.sv
`default_nettype none
// ============================================================================
// Module     : full_sub
// Purpose    : One-bit full subtractor x - y - bin, built from two
//              half-subtract stages joined by an OR on their borrows.
// Ports      : x_i, y_i, bin_i   minuend bit, subtrahend bit, borrow in
//              d_o               difference bit
//              bout_o            borrow out
// Revision   : 1.0  initial release
// ============================================================================
module full_sub (
   input  wire logic x_i,
   input  wire logic y_i,
   input  wire logic bin_i,
   output logic      d_o,
   output logic      bout_o
);
   logic w_d1;
   logic w_b1;
   logic w_b2;

   // First half-subtract: x - y
   assign w_d1 = x_i ^ y_i;
   assign w_b1 = ~x_i & y_i;

   // Second half-subtract: (x - y) - bin
   assign d_o  = w_d1 ^ bin_i;
   assign w_b2 = ~w_d1 & bin_i;

   // At most one stage can borrow, so OR merges them
   assign bout_o = w_b1 | w_b2;

endmodule : full_sub
`default_nettype wire

// File: rtl/serial_sub.sv
`default_nettype none
// ============================================================================
// Module     : serial_sub
// Purpose    : Bit-serial WIDTH-bit unsigned subtractor. Operands are loaded
//              in parallel, processed LSB-first one bit per clock through a
//              single full_sub cell with a borrow flip-flop, and the result
//              is published in parallel with a one-cycle done pulse.
// Ports      : clk     rising-edge clock
//              rst_n   asynchronous active-low reset
//              bus     serial_sub_if slave (start/a/b in, busy/done/diff/
//                      bout[/ovf] out)
// Options    : SERIAL_SUB_OVF_EN adds the signed overflow flag ovf
// Revision   : 1.0  initial release
// ============================================================================
module serial_sub
   import serial_sub_defs::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  wire logic     clk,
   input  wire logic     rst_n,
   serial_sub_if.slave   bus
);
   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   logic [1:0]       state_q;
   logic [1:0]       state_d;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] a_sr_q;
   logic [WIDTH-1:0] b_sr_q;
   logic [WIDTH-1:0] r_sr_q;
   logic             brw_q;
   logic [WIDTH-1:0] diff_q;
   logic             bout_q;

   logic             w_accept;
   logic             w_last;
   logic             w_d;
   logic             w_bo;
   logic [WIDTH-1:0] w_r_next;
   logic             busy_d;
   logic             done_d;

   // start is honoured whenever no operation is in flight, which includes
   // the DONE cycle so back-to-back operations need no idle gap
   assign w_accept = bus.start && (state_q != ST_SHIFT);
   assign w_last   = (cnt_q == CNT_LAST);
   assign w_r_next = {w_d, r_sr_q[WIDTH-1:1]};

   full_sub u_full_sub (
      .x_i    (a_sr_q[0]),
      .y_i    (b_sr_q[0]),
      .bin_i  (brw_q),
      .d_o    (w_d),
      .bout_o (w_bo)
   );

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (bus.start) state_d = ST_SHIFT;
         ST_SHIFT: if (w_last)    state_d = ST_DONE;
         ST_DONE:  state_d = bus.start ? ST_SHIFT : ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy_d = 1'b0;
      done_d = 1'b0;
      case (state_q)
         ST_SHIFT: busy_d = 1'b1;
         ST_DONE:  done_d = 1'b1;
         default:  ;
      endcase
   end

   // ----------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         a_sr_q <= '0;
         b_sr_q <= '0;
         r_sr_q <= '0;
         brw_q  <= 1'b0;
         diff_q <= '0;
         bout_q <= 1'b0;
      end else if (w_accept) begin
         cnt_q  <= '0;
         a_sr_q <= bus.a;
         b_sr_q <= bus.b;
         r_sr_q <= '0;
         brw_q  <= 1'b0;
      end else if (state_q == ST_SHIFT) begin
         cnt_q  <= cnt_q + CW'(1);
         a_sr_q <= a_sr_q >> 1;
         b_sr_q <= b_sr_q >> 1;
         r_sr_q <= w_r_next;
         brw_q  <= w_bo;
         // Result registers move only here, so a partial diff never shows
         if (w_last) begin
            diff_q <= w_r_next;
            bout_q <= w_bo;
         end
      end
   end

`ifdef SERIAL_SUB_OVF_EN
   // Only the operand sign bits are needed for overflow; keep them aside
   // because the shift registers lose them during the operation.
   logic a_msb_q;
   logic b_msb_q;
   logic ovf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (w_accept) begin
         a_msb_q <= bus.a[WIDTH-1];
         b_msb_q <= bus.b[WIDTH-1];
      end else if ((state_q == ST_SHIFT) && w_last) begin
         // The final d is the result MSB
         ovf_q <= (a_msb_q != b_msb_q) && (w_d != a_msb_q);
      end
   end

   assign bus.ovf = ovf_q;
`endif

   assign bus.busy = busy_d;
   assign bus.done = done_d;
   assign bus.diff = diff_q;
   assign bus.bout = bout_q;

endmodule : serial_sub
`default_nettype wire

// File: tb/tb_serial_sub.sv
`default_nettype none
// ============================================================================
// Module     : tb_serial_sub
// Purpose    : Directed self-checking bench for serial_sub (WIDTH=8).
// Options    : SERIAL_SUB_OVF_EN enables ovf checks
// Revision   : 1.0  initial release
// ============================================================================
module tb_serial_sub;
   localparam int unsigned W = 8;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   serial_sub_if #(.WIDTH(W)) bus ();

   serial_sub #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Launch one operation and wait for done. lat = edges from accept to done
   // visible (99 on timeout), bcnt = cycles busy was seen, early = diff moved
   // before done.
   task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                         output int lat, output int bcnt, output bit early);
      logic [W-1:0] d0;
      @(negedge clk);
      d0 = bus.diff;
      bus.start = 1'b1;
      bus.a     = av;
      bus.b     = bv;
      @(negedge clk);
      bus.start = 1'b0;
      bus.a     = ~av;
      bus.b     = ~bv;
      lat = 0; bcnt = 0; early = 1'b0;
      while (!bus.done && lat < 30) begin
         if (bus.busy) bcnt++;
         if (bus.diff !== d0) early = 1'b1;
         @(negedge clk);
         lat++;
      end
      if (!bus.done) lat = 99;
   endtask

   task automatic test_reset();
      bus.start = 1'b0; bus.a = '0; bus.b = '0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.busy, bus.done, bus.diff, bus.bout} !== 11'd0) begin
         errors++;
         $display("FAIL reset_state got busy=%b done=%b diff=%h bout=%b want all 0",
                  bus.busy, bus.done, bus.diff, bus.bout);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int lat, bcnt; bit early;
      run_op(8'h05, 8'h03, lat, bcnt, early);
      checks++;
      if (lat !== 8) begin errors++; $display("FAIL basic_latency got %0d want 8", lat); end
      checks++;
      if (bcnt !== 8) begin errors++; $display("FAIL basic_busy_cycles got %0d want 8", bcnt); end
      checks++;
      if (early !== 1'b0) begin errors++; $display("FAIL basic_diff_stable got early change want none"); end
      checks++;
      if ({bus.diff, bus.bout} !== {8'h02, 1'b0}) begin
         errors++; $display("FAIL basic_result got diff=%h bout=%b want 02/0", bus.diff, bus.bout);
      end
      @(negedge clk);
      checks++;
      if ({bus.done, bus.busy} !== 2'b00) begin
         errors++; $display("FAIL basic_done_pulse got done=%b busy=%b want 0/0", bus.done, bus.busy);
      end
   endtask

   task automatic test_underflow();
      int lat, bcnt; bit early;
      run_op(8'h03, 8'h05, lat, bcnt, early);
      checks++;
      if ({lat[7:0], bus.diff, bus.bout} !== {8'd8, 8'hFE, 1'b1}) begin
         errors++; $display("FAIL underflow got lat=%0d diff=%h bout=%b want 8/FE/1", lat, bus.diff, bus.bout);
      end
`ifdef SERIAL_SUB_OVF_EN
      checks++;
      if (bus.ovf !== 1'b0) begin errors++; $display("FAIL underflow_ovf got %b want 0", bus.ovf); end
`endif
   endtask

   task automatic test_overflow();
      int lat, bcnt; bit early;
      run_op(8'h80, 8'h01, lat, bcnt, early);
      checks++;
      if ({lat[7:0], bus.diff, bus.bout} !== {8'd8, 8'h7F, 1'b0}) begin
         errors++; $display("FAIL overflow got lat=%0d diff=%h bout=%b want 8/7F/0", lat, bus.diff, bus.bout);
      end
`ifdef SERIAL_SUB_OVF_EN
      checks++;
      if (bus.ovf !== 1'b1) begin errors++; $display("FAIL overflow_ovf got %b want 1", bus.ovf); end
`endif
      run_op(8'h00, 8'h00, lat, bcnt, early);
      checks++;
      if ({lat[7:0], bus.diff, bus.bout} !== {8'd8, 8'h00, 1'b0}) begin
         errors++; $display("FAIL zero_op got lat=%0d diff=%h bout=%b want 8/00/0", lat, bus.diff, bus.bout);
      end
   endtask

   task automatic test_back_to_back();
      int n, pulses;
      @(negedge clk);
      bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'h01;
      @(negedge clk);
      bus.start = 1'b0;
      n = 0; pulses = 0;
      while (!bus.done && n < 30) begin
         if (n == 3) begin bus.start = 1'b1; bus.a = 8'h00; bus.b = 8'h00; end
         else        bus.start = 1'b0;
         @(negedge clk);
         n++;
      end
      checks++;
      if ({bus.done, bus.diff, bus.bout} !== {1'b1, 8'hFE, 1'b0} || n !== 8) begin
         errors++; $display("FAIL ignored_start got done=%b n=%0d diff=%h bout=%b want 1/8/FE/0",
                            bus.done, n, bus.diff, bus.bout);
      end
`ifdef SERIAL_SUB_OVF_EN
      checks++;
      if (bus.ovf !== 1'b0) begin errors++; $display("FAIL ignored_start_ovf got %b want 0", bus.ovf); end
`endif
      // start during the DONE cycle
      bus.start = 1'b1; bus.a = 8'h10; bus.b = 8'h20;
      @(negedge clk);
      bus.start = 1'b0; bus.a = 8'h00; bus.b = 8'h00;
      checks++;
      if ({bus.busy, bus.done} !== 2'b10) begin
         errors++; $display("FAIL b2b_no_gap got busy=%b done=%b want 1/0", bus.busy, bus.done);
      end
      n = 0;
      while (!bus.done && n < 30) begin
         @(negedge clk);
         n++;
         if (bus.done) pulses++;
      end
      checks++;
      if ({bus.diff, bus.bout} !== {8'hF0, 1'b1} || n !== 8 || pulses !== 1) begin
         errors++; $display("FAIL b2b_result got diff=%h bout=%b n=%0d pulses=%0d want F0/1/8/1",
                            bus.diff, bus.bout, n, pulses);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_midop();
      int lat, bcnt; bit early;
      @(negedge clk);
      bus.start = 1'b1; bus.a = 8'hAA; bus.b = 8'h55;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.busy, bus.done, bus.diff, bus.bout} !== 11'd0) begin
         errors++; $display("FAIL midop_reset got busy=%b done=%b diff=%h bout=%b want all 0",
                            bus.busy, bus.done, bus.diff, bus.bout);
      end
      @(negedge clk);
      rst_n = 1'b1;
      run_op(8'h0A, 8'h0A, lat, bcnt, early);
      checks++;
      if ({lat[7:0], bus.diff, bus.bout} !== {8'd8, 8'h00, 1'b0}) begin
         errors++; $display("FAIL post_reset_op got lat=%0d diff=%h bout=%b want 8/00/0", lat, bus.diff, bus.bout);
      end
   endtask

   task automatic test_random();
      int lat, bcnt; bit early;
      logic [W-1:0] av, bv, ed;
      logic eb;
      for (int i = 0; i < 20; i++) begin
         av = W'($urandom_range(0, 255));
         bv = W'($urandom_range(0, 255));
         ed = av - bv;
         eb = (av < bv);
         run_op(av, bv, lat, bcnt, early);
         checks++;
         if ({lat[7:0], bus.diff, bus.bout} !== {8'd8, ed, eb}) begin
            errors++; $display("FAIL random a=%h b=%h got lat=%0d diff=%h bout=%b want 8/%h/%b",
                               av, bv, lat, bus.diff, bus.bout, ed, eb);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_basic();
      test_underflow();
      test_overflow();
      test_back_to_back();
      test_reset_midop();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_serial_sub
`default_nettype wire
